ps2_rx: RTL and testbench
=========================

# ps2_rx

Upstream receive stage of the keyboard path. Synchronises and glitch-filters the raw PS/2 clock and data lines, deserialises 11-bit device-to-host frames into bytes on the system clock, checks parity and stop bit, and folds E0/F0 prefixes into make/break key events. Its byte output is the scan-code input to the keyboard colour decoder; its key-event outputs serve later consumers that need release information.

## Interface
- FILTER_LEN, 8: consecutive identical samples required before a filtered line changes level (≥2)
- TIMEOUT, 50000: clk cycles without a filtered clock edge before an in-progress frame is abandoned (1 ms at 50 MHz)
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high
- PS2_CLOCK  in  1  raw PS/2 clock, asynchronous, idle high
- PS2_DATA  in  1  raw PS/2 data, asynchronous, idle high
- rxdata  out  8  last good byte received; holds until next good byte
- rx_valid  out  1  one-cycle pulse per good byte, including prefix bytes
- scan_code  out  8  key code of last completed event (prefixes stripped)
- scan_valid  out  1  one-cycle pulse per completed key event
- scan_release  out  1  event was a break (F0 seen); valid with scan_valid
- scan_extended  out  1  event was extended (E0 seen); valid with scan_valid
- frame_err  out  1  one-cycle pulse on parity, stop-bit, or timeout error

## Operation
- Each line: 2-FF synchroniser (reset to 1), then filter; filtered level changes only after FILTER_LEN consecutive synchronised samples of the new level. Both lines use identical filters so delays match.
- Falling edge = filtered clock 1→0 in this cycle; bits sampled from filtered data in that cycle.
- FSM: IDLE → DATA → PARITY → STOP → IDLE.
  - IDLE: on falling edge with data 0 (start) → DATA, bit count 0. Data 1 at edge: ignored, stay IDLE, no error.
  - DATA: shift in LSB first; after 8th bit → PARITY.
  - PARITY: store bit → STOP.
  - STOP: on edge, if data 1 and ones-count over 8 data bits + parity is odd → good byte; else frame_err. Either way → IDLE.
- Timeout counter, width $clog2(TIMEOUT+1): cleared on every falling edge and in IDLE; increments otherwise. Reaching TIMEOUT-1 outside IDLE → IDLE, frame_err pulse, partial byte discarded.
- Good byte: rxdata ← byte, rx_valid pulse. Decoder:
  - E0: set pending_ext, no scan_valid.
  - F0: set pending_rel, no scan_valid.
  - Any other (incl. E1): scan_code ← byte, scan_release ← pending_rel, scan_extended ← pending_ext, scan_valid pulse, clear both pending flags.
- Any frame_err clears pending_ext and pending_rel.

## Timing
- Reset: FSM IDLE, sync/filter state 1, counters 0, rxdata/scan_code 8'h00, all pulses and flags 0, pending flags 0. Reset mid-frame discards the partial byte with no frame_err.
- rx_valid and frame_err: high in the cycle after the stop-bit (or timeout) detection cycle, exactly one cycle.
- scan_valid: one cycle after the rx_valid of the same byte; scan_release/scan_extended/scan_code are registered and stable from that cycle until the next event.
- Raw stop-bit clock fall to rx_valid: at most FILTER_LEN+4 cycles.
- Pulses never overlap a second byte. PS/2 bit period (≥60 µs) exceeds all internal latencies, so no back-pressure or buffering is needed. Downstream must capture on the pulse.

## Structure
- Package ps2_pkg: FSM state enum, PS2_PREFIX_EXT = 8'hE0, PS2_PREFIX_BREAK = 8'hF0, PS2_FRAME_BITS = 11.
- Sub-module ps2_line_filter (param FILTER_LEN; clk, reset, raw in, filtered out). Instantiated twice, for clock and data.
- FSM, shift register, parity check, timeout, and prefix decoder stay in ps2_rx.

## Test plan
- Frame 0x1C (parity 0, stop 1), 12.5 kHz clock → one rx_valid with rxdata=8'h1C; one scan_valid with scan_code=8'h1C, release=0, extended=0.
- F0, 1C → two rx_valid (F0, 1C); one scan_valid with code 8'h1C, release=1, extended=0.
- E0, F0, 75 → three rx_valid; one scan_valid with code 8'h75, release=1, extended=1; following 0x1B → release=0, extended=0.
- F0 then 0x1B with parity 0 (bad) → frame_err pulse, no rx_valid for 0x1B, no scan_valid; next 0x23 → scan_release=0.
- Stop clocking after 5 bits for TIMEOUT cycles → frame_err once, FSM IDLE; then 0x2B → scan_code=8'h2B. 3-cycle low glitch on PS2_CLOCK in IDLE (FILTER_LEN=8) → no state change, no pulses.
- Assert reset for 1 cycle mid-way through a 0x1C frame → all outputs 0, no frame_err; next full 0x1C frame decodes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0]  PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0]  PS2_PREFIX_BREAK = 8'hF0;
  localparam int unsigned PS2_FRAME_BITS   = 11;
  // Start, parity and stop wrap the payload.
  localparam int unsigned PS2_DATA_BITS    = PS2_FRAME_BITS - 3;

  // PS/2 uses odd parity over the 8 data bits plus the parity bit.
  function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter for one PS/2 line.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam int unsigned CW = $clog2(FILTER_LEN);

  logic          meta_q, meta_d;
  logic          sync_q, sync_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count consecutive samples that disagree with the filtered level; flip on the FILTER_LEN-th.
  always_comb begin
    meta_d  = raw;
    sync_d  = meta_q;
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q != level_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        level_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchroniser and filter state; lines idle high so everything resets to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      meta_q  <= meta_d;
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filtered = level_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver: frame deserialiser, parity/stop check, timeout and E0/F0 prefix folding.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2_CLOCK,
  input  logic       PS2_DATA,
  output logic [7:0] rxdata,
  output logic       rx_valid,
  output logic [7:0] scan_code,
  output logic       scan_valid,
  output logic       scan_release,
  output logic       scan_extended,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic clk_filt;
  logic data_filt;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk      (clk),
    .reset    (reset),
    .raw      (PS2_CLOCK),
    .filtered (clk_filt)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk      (clk),
    .reset    (reset),
    .raw      (PS2_DATA),
    .filtered (data_filt)
  );

  logic          clk_prev_q, clk_prev_d;
  logic          fall;
  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    rxdata_q, rxdata_d;
  logic          rx_valid_q, rx_valid_d;
  logic          frame_err_q, frame_err_d;
  logic          pend_ext_q, pend_ext_d;
  logic          pend_rel_q, pend_rel_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          scan_valid_q, scan_valid_d;
  logic          scan_rel_q, scan_rel_d;
  logic          scan_ext_q, scan_ext_d;

  assign fall = clk_prev_q & ~clk_filt;

  // Frame FSM, shift register and inactivity timeout.
  always_comb begin
    clk_prev_d  = clk_filt;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    rxdata_d    = rxdata_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    to_cnt_d    = (state_q == ST_IDLE || fall) ? '0 : to_cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (fall && !data_filt) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_d   = {data_filt, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'(PS2_DATA_BITS - 1)) begin
            state_d = ST_PARITY;
          end
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_d   = data_filt;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          if (data_filt && ps2_parity_ok(shift_q, par_q)) begin
            rxdata_d   = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A stalled frame is abandoned; a clock edge in the same cycle takes precedence.
    if (state_q != ST_IDLE && !fall && to_cnt_q == TW'(TIMEOUT - 1)) begin
      state_d     = ST_IDLE;
      frame_err_d = 1'b1;
    end
  end

  // Prefix decoder runs one cycle behind the byte register so scan_valid trails rx_valid.
  always_comb begin
    pend_ext_d   = pend_ext_q;
    pend_rel_d   = pend_rel_q;
    scan_code_d  = scan_code_q;
    scan_rel_d   = scan_rel_q;
    scan_ext_d   = scan_ext_q;
    scan_valid_d = 1'b0;
    if (frame_err_q) begin
      pend_ext_d = 1'b0;
      pend_rel_d = 1'b0;
    end else if (rx_valid_q) begin
      if (rxdata_q == PS2_PREFIX_EXT) begin
        pend_ext_d = 1'b1;
      end else if (rxdata_q == PS2_PREFIX_BREAK) begin
        pend_rel_d = 1'b1;
      end else begin
        scan_code_d  = rxdata_q;
        scan_rel_d   = pend_rel_q;
        scan_ext_d   = pend_ext_q;
        scan_valid_d = 1'b1;
        pend_ext_d   = 1'b0;
        pend_rel_d   = 1'b0;
      end
    end
  end

  // State registers for the receiver and decoder.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_prev_q   <= 1'b1;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      rxdata_q     <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      pend_ext_q   <= 1'b0;
      pend_rel_q   <= 1'b0;
      scan_code_q  <= '0;
      scan_valid_q <= 1'b0;
      scan_rel_q   <= 1'b0;
      scan_ext_q   <= 1'b0;
    end else begin
      clk_prev_q   <= clk_prev_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      rxdata_q     <= rxdata_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      pend_ext_q   <= pend_ext_d;
      pend_rel_q   <= pend_rel_d;
      scan_code_q  <= scan_code_d;
      scan_valid_q <= scan_valid_d;
      scan_rel_q   <= scan_rel_d;
      scan_ext_q   <= scan_ext_d;
    end
  end

  assign rxdata        = rxdata_q;
  assign rx_valid      = rx_valid_q;
  assign frame_err     = frame_err_q;
  assign scan_code     = scan_code_q;
  assign scan_valid    = scan_valid_q;
  assign scan_release  = scan_rel_q;
  assign scan_extended = scan_ext_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed bench for ps2_rx: table of frames plus timeout, glitch and reset sequences.
module tb_ps2_rx;

  localparam int FL = 8;
  localparam int TO = 500;
  localparam int H  = 40;   // PS/2 half bit period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2c;
  logic       ps2d;
  logic [7:0] rxdata;
  logic       rx_valid;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic       scan_release;
  logic       scan_extended;
  logic       frame_err;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .reset         (reset),
    .PS2_CLOCK     (ps2c),
    .PS2_DATA      (ps2d),
    .rxdata        (rxdata),
    .rx_valid      (rx_valid),
    .scan_code     (scan_code),
    .scan_valid    (scan_valid),
    .scan_release  (scan_release),
    .scan_extended (scan_extended),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts cycles each pulse is high and checks scan_valid trails rx_valid.
  int   rx_cnt = 0, scan_cnt = 0, err_cnt = 0, seq_err = 0, rx_cyc = 0;
  logic prev_rx = 1'b0;
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_cyc = cyc;
    end
    if (frame_err) err_cnt++;
    if (scan_valid) begin
      scan_cnt++;
      if (!prev_rx) seq_err++;
    end
    prev_rx = rx_valid;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int stop_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive the first nbits bits of an 11-bit frame; lines are left idle high afterwards.
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop, input int nbits);
    logic [10:0] fr;
    logic        par;
    par = ~(^d);
    if (bad_par) par = ~par;
    fr = {~bad_stop, par, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2d = fr[i];
      repeat (H) @(negedge clk);
      ps2c = 1'b0;
      if (i == 10) stop_cyc = cyc;
      repeat (H) @(negedge clk);
      ps2c = 1'b1;
    end
    ps2d = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         bad_par;
    bit         bad_stop;
    int         rx_n;
    int         scan_n;
    int         err_n;
    logic [7:0] rxd;
    logic [7:0] code;
    logic       rel;
    logic       ext;
  } vec_t;

  vec_t vecs[14];

  int b_rx, b_scan, b_err, b_seq;

  task automatic snap();
    b_rx = rx_cnt; b_scan = scan_cnt; b_err = err_cnt; b_seq = seq_err;
  endtask

  initial begin
    vecs[0]  = '{8'h1C, 1'b0, 1'b0, 1, 1, 0, 8'h1C, 8'h1C, 1'b0, 1'b0};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 1, 0, 0, 8'hF0, 8'h1C, 1'b0, 1'b0};
    vecs[2]  = '{8'h1C, 1'b0, 1'b0, 1, 1, 0, 8'h1C, 8'h1C, 1'b1, 1'b0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 1, 0, 0, 8'hE0, 8'h1C, 1'b1, 1'b0};
    vecs[4]  = '{8'hF0, 1'b0, 1'b0, 1, 0, 0, 8'hF0, 8'h1C, 1'b1, 1'b0};
    vecs[5]  = '{8'h75, 1'b0, 1'b0, 1, 1, 0, 8'h75, 8'h75, 1'b1, 1'b1};
    vecs[6]  = '{8'h1B, 1'b0, 1'b0, 1, 1, 0, 8'h1B, 8'h1B, 1'b0, 1'b0};
    vecs[7]  = '{8'hF0, 1'b0, 1'b0, 1, 0, 0, 8'hF0, 8'h1B, 1'b0, 1'b0};
    vecs[8]  = '{8'h1B, 1'b1, 1'b0, 0, 0, 1, 8'hF0, 8'h1B, 1'b0, 1'b0};
    vecs[9]  = '{8'h23, 1'b0, 1'b0, 1, 1, 0, 8'h23, 8'h23, 1'b0, 1'b0};
    vecs[10] = '{8'hE0, 1'b0, 1'b0, 1, 0, 0, 8'hE0, 8'h23, 1'b0, 1'b0};
    vecs[11] = '{8'h34, 1'b0, 1'b1, 0, 0, 1, 8'hE0, 8'h23, 1'b0, 1'b0};
    vecs[12] = '{8'h34, 1'b0, 1'b0, 1, 1, 0, 8'h34, 8'h34, 1'b0, 1'b0};
    vecs[13] = '{8'hE1, 1'b0, 1'b0, 1, 1, 0, 8'hE1, 8'hE1, 1'b0, 1'b0};

    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("reset_rxdata",    int'(rxdata), 0);
    check("reset_scan_code", int'(scan_code), 0);
    check("reset_flags",     int'({scan_release, scan_extended}), 0);
    check("reset_pulses",    rx_cnt + scan_cnt + err_cnt, 0);

    foreach (vecs[i]) begin
      snap();
      send_frame(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 11);
      check($sformatf("v%0d_rx_n", i),   rx_cnt - b_rx, vecs[i].rx_n);
      check($sformatf("v%0d_scan_n", i), scan_cnt - b_scan, vecs[i].scan_n);
      check($sformatf("v%0d_err_n", i),  err_cnt - b_err, vecs[i].err_n);
      check($sformatf("v%0d_rxdata", i), int'(rxdata), int'(vecs[i].rxd));
      check($sformatf("v%0d_code", i),   int'(scan_code), int'(vecs[i].code));
      check($sformatf("v%0d_rel", i),    int'(scan_release), int'(vecs[i].rel));
      check($sformatf("v%0d_ext", i),    int'(scan_extended), int'(vecs[i].ext));
      check($sformatf("v%0d_seq", i),    seq_err - b_seq, 0);
      if (vecs[i].rx_n == 1)
        check($sformatf("v%0d_latency_le_%0d", i, FL + 4), int'((rx_cyc - stop_cyc) <= FL + 4), 1);
    end

    // Timeout: F0 pending, then a frame that stops after 5 bits.
    snap();
    send_frame(8'hF0, 1'b0, 1'b0, 11);
    send_frame(8'h55, 1'b0, 1'b0, 5);
    repeat (TO + 200) @(negedge clk);
    check("to_err_n", err_cnt - b_err, 1);
    check("to_rx_n",  rx_cnt - b_rx, 1);
    check("to_scan_n", scan_cnt - b_scan, 0);
    snap();
    send_frame(8'h2B, 1'b0, 1'b0, 11);
    check("to_next_code", int'(scan_code), 8'h2B);
    check("to_next_rel",  int'(scan_release), 0);
    check("to_next_scan_n", scan_cnt - b_scan, 1);

    // Short glitch, then a full clock pulse with data high: both ignored in idle.
    snap();
    ps2c = 1'b0;
    repeat (3) @(negedge clk);
    ps2c = 1'b1;
    repeat (50) @(negedge clk);
    ps2c = 1'b0;
    repeat (H) @(negedge clk);
    ps2c = 1'b1;
    repeat (TO + 100) @(negedge clk);
    check("glitch_pulses", (rx_cnt - b_rx) + (scan_cnt - b_scan) + (err_cnt - b_err), 0);
    check("glitch_rxdata", int'(rxdata), 8'h2B);
    snap();
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    check("glitch_next_code", int'(scan_code), 8'h1C);
    check("glitch_next_scan_n", scan_cnt - b_scan, 1);

    // Reset mid-frame with E0 pending.
    send_frame(8'hE0, 1'b0, 1'b0, 11);
    send_frame(8'h1C, 1'b0, 1'b0, 5);
    snap();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_rxdata",    int'(rxdata), 0);
    check("rst_scan_code", int'(scan_code), 0);
    check("rst_outs",      int'({rx_valid, scan_valid, scan_release, scan_extended, frame_err}), 0);
    repeat (TO + 200) @(negedge clk);
    check("rst_no_err", err_cnt - b_err, 0);
    snap();
    send_frame(8'h1C, 1'b0, 1'b0, 11);
    check("rst_next_rx_n", rx_cnt - b_rx, 1);
    check("rst_next_code", int'(scan_code), 8'h1C);
    check("rst_next_flags", int'({scan_release, scan_extended}), 0);
    check("rst_next_scan_n", scan_cnt - b_scan, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
